// File: rtl/br_redirect_ctrl.sv
// Taken-branch redirect sequencer: holds a resolved target until the delay slot has reached ID,
// then requests an IF redirect; exception/eret flushes always take precedence.
module br_redirect_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        br_fire,
  input  logic [31:0] br_target,
  input  logic        ds_fetched,
  input  logic        fs_fire,
  input  logic        redir_ready,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  output logic        fs_hold,
  output logic        busy,
  output logic        illegal_ds,
  output logic [31:0] br_cnt,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_DS = 2'd1;
  localparam logic [1:0] ST_SEND    = 2'd2;

  // Handshake: a redirect transfers on a cycle where redir_valid & redir_ready are both high;
  // redir_valid/redir_pc stay stable while redir_ready is low, and IF drops its
  // in-flight instruction on the transfer cycle.

  logic [1:0]  state_q, state_d;
  logic [31:0] tgt_q, tgt_d;
  logic        ill_q, ill_d;
  logic [31:0] cnt_q, cnt_d;

  logic in_send;
  logic accept;

  assign in_send = (state_q == ST_SEND);
  assign accept  = in_send & redir_ready & ~flush;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
    if (flush) begin
      // A flush discards any pending branch and wins over a branch firing in the same cycle.
      state_d = ST_IDLE;
      ill_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (br_fire) begin
            tgt_d   = br_target;
            state_d = ds_fetched ? ST_SEND : ST_WAIT_DS;
          end
        end
        ST_WAIT_DS: begin
          if (br_fire) ill_d = 1'b1;
          if (fs_fire) state_d = ST_SEND;
        end
        ST_SEND: begin
          if (br_fire) ill_d = 1'b1;
          if (redir_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
      if (accept) cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tgt_q   <= 32'd0;
      ill_q   <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign redir_valid = flush | in_send;
  assign redir_pc    = flush ? flush_pc : tgt_q;
  assign fs_hold     = in_send & ~flush;
  assign busy        = (state_q != ST_IDLE);
  assign illegal_ds  = ill_q;
  assign br_cnt      = cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_br_redirect_ctrl.sv
// Bench for br_redirect_ctrl: a cycle-by-cycle vector table through a scoreboard queue,
// then hand sequences for reset during a pending branch and br_cnt wrap.
module tb_br_redirect_ctrl;

  localparam int OW = 68;

  typedef struct packed {
    logic        rv;
    logic [31:0] pc;
    logic        hold;
    logic        busy;
    logic        ill;
    logic [31:0] cnt;
  } out_t;

  typedef struct {
    logic        bf;
    logic [31:0] bt;
    logic        dsf;
    logic        ff;
    logic        rr;
    logic        fl;
    logic [31:0] fpc;
    out_t        exp;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        br_fire;
  logic [31:0] br_target;
  logic        ds_fetched;
  logic        fs_fire;
  logic        redir_ready;
  logic        flush;
  logic [31:0] flush_pc;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        fs_hold;
  logic        busy;
  logic        illegal_ds;
  logic [31:0] br_cnt;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  vec_t vecs[$];
  logic [OW-1:0] exp_q[$];

  br_redirect_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .br_fire    (br_fire),
    .br_target  (br_target),
    .ds_fetched (ds_fetched),
    .fs_fire    (fs_fire),
    .redir_ready(redir_ready),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .redir_valid(redir_valid),
    .redir_pc   (redir_pc),
    .fs_hold    (fs_hold),
    .busy       (busy),
    .illegal_ds (illegal_ds),
    .br_cnt     (br_cnt),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void add(input logic bf, input logic [31:0] bt, input logic dsf,
                              input logic ff, input logic rr, input logic fl,
                              input logic [31:0] fpc, input logic rv, input logic [31:0] pc,
                              input logic hold, input logic bsy, input logic ill,
                              input logic [31:0] cnt);
    vec_t v;
    v.bf = bf; v.bt = bt; v.dsf = dsf; v.ff = ff; v.rr = rr; v.fl = fl; v.fpc = fpc;
    v.exp.rv = rv; v.exp.pc = pc; v.exp.hold = hold; v.exp.busy = bsy;
    v.exp.ill = ill; v.exp.cnt = cnt;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    br_fire = 1'b0; br_target = 32'd0; ds_fetched = 1'b0; fs_fire = 1'b0;
    redir_ready = 1'b0; flush = 1'b0; flush_pc = 32'd0;
  endtask

  task automatic drive_vec(input vec_t v);
    br_fire = v.bf; br_target = v.bt; ds_fetched = v.dsf; fs_fire = v.ff;
    redir_ready = v.rr; flush = v.fl; flush_pc = v.fpc;
    exp_q.push_back(OW'(v.exp));
  endtask

  task automatic score(input int idx);
    out_t e;
    string tag;
    if (exp_q.size() == 0) begin
      chk($sformatf("row%0d_queue_empty", idx), 32'd0, 32'd1);
      return;
    end
    e = out_t'(exp_q.pop_front());
    tag = $sformatf("row%0d", idx);
    chk({tag, "_redir_valid"}, {31'd0, redir_valid}, {31'd0, e.rv});
    chk({tag, "_redir_pc"},    redir_pc,             e.pc);
    chk({tag, "_fs_hold"},     {31'd0, fs_hold},     {31'd0, e.hold});
    chk({tag, "_busy"},        {31'd0, busy},        {31'd0, e.busy});
    chk({tag, "_illegal_ds"},  {31'd0, illegal_ds},  {31'd0, e.ill});
    chk({tag, "_br_cnt"},      br_cnt,               e.cnt);
  endtask

  initial begin
    drive_idle();
    reset = 1'b1;

    // bf  bt            dsf ff rr fl fpc             rv pc            hold busy ill cnt
    add(0, 32'h0,        0, 0, 0, 0, 32'h0,          0, 32'h0,        0, 0, 0, 32'd0);
    add(1, 32'hBFC00100, 1, 0, 0, 0, 32'h0,          0, 32'h0,        0, 0, 0, 32'd0);
    add(0, 32'h0,        0, 0, 1, 0, 32'h0,          1, 32'hBFC00100, 1, 1, 0, 32'd0);
    add(0, 32'h0,        0, 0, 0, 0, 32'h0,          0, 32'hBFC00100, 0, 0, 0, 32'd1);
    add(1, 32'h80001000, 0, 0, 0, 0, 32'h0,          0, 32'hBFC00100, 0, 0, 0, 32'd1);
    add(0, 32'h0,        0, 0, 0, 0, 32'h0,          0, 32'h80001000, 0, 1, 0, 32'd1);
    add(0, 32'h0,        0, 0, 1, 0, 32'h0,          0, 32'h80001000, 0, 1, 0, 32'd1);
    add(0, 32'h0,        0, 1, 0, 0, 32'h0,          0, 32'h80001000, 0, 1, 0, 32'd1);
    for (int i = 0; i < 4; i++)
      add(0, 32'h0,      0, 0, 0, 0, 32'h0,          1, 32'h80001000, 1, 1, 0, 32'd1);
    add(0, 32'h0,        0, 0, 1, 0, 32'h0,          1, 32'h80001000, 1, 1, 0, 32'd1);
    add(0, 32'h0,        0, 0, 0, 0, 32'h0,          0, 32'h80001000, 0, 0, 0, 32'd2);
    add(1, 32'h12340000, 1, 0, 0, 0, 32'h0,          0, 32'h80001000, 0, 0, 0, 32'd2);
    add(0, 32'h0,        0, 0, 1, 1, 32'hBFC00380,   1, 32'hBFC00380, 0, 1, 0, 32'd2);
    add(0, 32'h0,        0, 0, 0, 0, 32'h0,          0, 32'h12340000, 0, 0, 0, 32'd2);
    add(1, 32'h90000000, 0, 0, 0, 0, 32'h0,          0, 32'h12340000, 0, 0, 0, 32'd2);
    add(1, 32'hDEAD0000, 1, 0, 0, 0, 32'h0,          0, 32'h90000000, 0, 1, 0, 32'd2);
    add(0, 32'h0,        0, 0, 0, 0, 32'h0,          0, 32'h90000000, 0, 1, 1, 32'd2);
    add(0, 32'h0,        0, 1, 0, 0, 32'h0,          0, 32'h90000000, 0, 1, 1, 32'd2);
    add(1, 32'h55550000, 1, 0, 0, 0, 32'h0,          1, 32'h90000000, 1, 1, 1, 32'd2);
    add(0, 32'h0,        0, 0, 1, 0, 32'h0,          1, 32'h90000000, 1, 1, 1, 32'd2);
    add(0, 32'h0,        0, 0, 0, 0, 32'h0,          0, 32'h90000000, 0, 0, 1, 32'd3);
    add(0, 32'h0,        0, 0, 0, 1, 32'hBFC00380,   1, 32'hBFC00380, 0, 0, 1, 32'd3);
    add(0, 32'h0,        0, 0, 0, 0, 32'h0,          0, 32'h90000000, 0, 0, 0, 32'd3);
    add(1, 32'hA0000000, 0, 0, 0, 0, 32'h0,          0, 32'h90000000, 0, 0, 0, 32'd3);
    add(1, 32'hB0000000, 1, 1, 1, 1, 32'h80000180,   1, 32'h80000180, 0, 1, 0, 32'd3);
    add(0, 32'h0,        0, 0, 0, 0, 32'h0,          0, 32'hA0000000, 0, 0, 0, 32'd3);

    repeat (2) @(negedge clk);
    #1;
    chk("reset_redir_valid", {31'd0, redir_valid}, 32'd0);
    chk("reset_redir_pc",    redir_pc,             32'd0);
    chk("reset_busy",        {31'd0, busy},        32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive_vec(vecs[i]);
      #1;
      score(i);
    end

    // reset while waiting for the delay slot: pending branch is dropped
    @(negedge clk);
    drive_idle();
    br_fire = 1'b1; br_target = 32'hC0000000; ds_fetched = 1'b0;
    @(negedge clk);
    drive_idle();
    #1;
    chk("rst_wait_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_wait_busy",   {31'd0, busy},       32'd0);
    chk("rst_wait_pc",     redir_pc,            32'd0);
    chk("rst_wait_cnt",    br_cnt,              32'd0);
    chk("rst_wait_ill",    {31'd0, illegal_ds}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    fs_fire = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      fs_fire = 1'b0;
      #1;
      chk($sformatf("rst_wait_no_pulse%0d", i), {31'd0, redir_valid}, 32'd0);
    end

    // asynchronous reset mid-SEND, observed with no clock edge in between
    @(negedge clk);
    br_fire = 1'b1; br_target = 32'hC0000004; ds_fetched = 1'b1;
    @(negedge clk);
    drive_idle();
    #1;
    chk("rst_send_rv_before", {31'd0, redir_valid}, 32'd1);
    chk("rst_send_pc_before", redir_pc,             32'hC0000004);
    reset = 1'b1;
    #1;
    chk("rst_send_rv",   {31'd0, redir_valid}, 32'd0);
    chk("rst_send_pc",   redir_pc,             32'd0);
    chk("rst_send_hold", {31'd0, fs_hold},     32'd0);
    chk("rst_send_busy", {31'd0, busy},        32'd0);
    flush = 1'b1; flush_pc = 32'h12345678;
    #1;
    chk("rst_flush_rv", {31'd0, redir_valid}, 32'd1);
    chk("rst_flush_pc", redir_pc,             32'h12345678);
    flush = 1'b0; flush_pc = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    redir_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst_send_no_pulse%0d", i), {31'd0, redir_valid}, 32'd0);
      chk($sformatf("rst_send_cnt%0d", i),      br_cnt,               32'd0);
    end
    redir_ready = 1'b0;

    // br_cnt wrap: preload all-ones, then complete one redirect
    @(negedge clk);
    force dut.cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.cnt_q;
    #1;
    chk("wrap_preload", br_cnt, 32'hFFFFFFFF);
    @(negedge clk);
    br_fire = 1'b1; br_target = 32'h00000040; ds_fetched = 1'b1;
    @(negedge clk);
    drive_idle();
    redir_ready = 1'b1;
    #1;
    chk("wrap_rv",         {31'd0, redir_valid}, 32'd1);
    chk("wrap_cnt_before", br_cnt,               32'hFFFFFFFF);
    @(negedge clk);
    redir_ready = 1'b0;
    #1;
    chk("wrap_cnt", br_cnt,        32'd0);
    chk("wrap_busy", {31'd0, busy}, 32'd0);

    if (exp_q.size() != 0) chk("scoreboard_leftover", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/br_redirect_ctrl.md
BR_REDIRECT_CTRL -- requirements
Module: br_redirect_ctrl

Interface
REQ-001 SHALL have no parameters; all widths fixed (virt_t = 32 bits).
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 br_fire  in  1  ID branch/jump with br_taken=1 leaves ID this cycle (ds_valid & ds_allowin & ~br_stall).
REQ-005 br_target  in  32  target from branch resolution, valid with br_fire.
REQ-006 ds_fetched  in  1  delay-slot instruction already valid in IF when br_fire.
REQ-007 fs_fire  in  1  IF hands one instruction to ID this cycle.
REQ-008 redir_ready  in  1  IF PC register accepts redirect this cycle.
REQ-009 flush  in  1  exception/eret redirect request, highest priority.
REQ-010 flush_pc  in  32  redirect address for flush.
REQ-011 redir_valid  out  1  redirect request to IF.
REQ-012 redir_pc  out  32  redirect address.
REQ-013 fs_hold  out  1  IF shall not pass further instructions to ID.
REQ-014 busy  out  1  a taken branch is pending (state != IDLE).
REQ-015 illegal_ds  out  1  sticky flag: branch fired in a delay slot.
REQ-016 br_cnt  out  32  count of completed branch redirects.

Function
REQ-017 States SHALL be IDLE, WAIT_DS, SEND; encoding free.
REQ-018 IDLE: br_fire & ds_fetched -> SEND; br_fire & ~ds_fetched -> WAIT_DS; else stay.
REQ-019 On br_fire in IDLE, tgt register SHALL latch br_target.
REQ-020 WAIT_DS: fs_fire (delay slot delivered to ID) -> SEND; else stay.
REQ-021 SEND: redir_ready -> IDLE; else stay, tgt held stable.
REQ-022 redir_valid SHALL be flush | (state==SEND), combinational.
REQ-023 redir_pc SHALL be flush_pc when flush, else tgt.
REQ-024 fs_hold SHALL be (state==SEND) & ~flush, blocking wrong-path instructions after the delay slot.
REQ-025 IF discards its in-flight instruction on redir_valid & redir_ready; this block issues no separate kill.
REQ-026 Latency: br_fire with ds_fetched=1 -> redir_valid on the next cycle; with ds_fetched=0 -> redir_valid the cycle after fs_fire.
REQ-027 br_fire in WAIT_DS or SEND SHALL be ignored for state/tgt and SHALL set illegal_ds.
REQ-028 flush in any state SHALL force state to IDLE next cycle, overriding br_fire, fs_fire and redir_ready in the same cycle.
REQ-029 flush SHALL clear illegal_ds; if br_fire coincides with flush, illegal_ds is cleared, not set.
REQ-030 br_cnt SHALL increment by 1 on (state==SEND) & redir_ready & ~flush, wrapping 0xFFFFFFFF -> 0.
REQ-031 redir_ready while state!=SEND and ~flush SHALL have no effect.
REQ-032 busy SHALL be (state != IDLE).

Reset
REQ-033 On reset: state=IDLE, tgt=0, br_cnt=0, illegal_ds=0; hence redir_valid=flush, redir_pc=flush ? flush_pc : 0, fs_hold=0, busy=0.
REQ-034 Reset asserted mid-WAIT_DS or mid-SEND SHALL abandon the pending redirect with no output pulse after release.

Verification
REQ-035 br_fire, br_target=0xBFC00100, ds_fetched=1, redir_ready=1 next cycle -> cycle+1 redir_valid=1, redir_pc=0xBFC00100, fs_hold=1; cycle+2 IDLE, br_cnt=1.
REQ-036 br_fire, ds_fetched=0, target=0x80001000; fs_fire 3 cycles later -> busy=1, redir_valid=0 until cycle after fs_fire, then redir_pc=0x80001000.
REQ-037 SEND with redir_ready=0 for 4 cycles -> redir_valid and redir_pc=tgt stable all 4 cycles, br_cnt unchanged until accept.
REQ-038 flush=1, flush_pc=0xBFC00380 while in SEND with redir_ready=1 -> redir_pc=0xBFC00380, next state IDLE, br_cnt unchanged.
REQ-039 br_fire while in WAIT_DS -> tgt unchanged, illegal_ds=1; later flush -> illegal_ds=0.
REQ-040 br_cnt preloaded to 0xFFFFFFFF via repeated branches (or forced) plus one completed redirect -> br_cnt=0; async reset mid-SEND -> outputs per REQ-033 immediately, no clock required.
